// File: rtl/abs16_rr_arbiter.sv
// abs16_rr_arbiter
//   Shares one combinational abs16 datapath between NREQ valid/ready
//   requesters. A rotating-priority grant selects one operand per cycle.
//   The magnitude is captured in a single response register, tagged with
//   the index of the requester that produced it.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_valid[NREQ] per-requester request valid
//   req_data        NREQ*N operands, requester i at [i*N +: N]
//   req_ready[NREQ] one-hot-or-zero accept (combinational)
//   rsp_valid       response register holds a result
//   rsp_data        |operand| (0x8000 maps to 0x8000)
//   rsp_id          requester index of rsp_data
//   rsp_ovf         operand was 0x8000
//   rsp_ready       consumer accepts the response
//   ovf_count       saturating count of accepted 0x8000 operands

// Two's-complement absolute value. 0x8000 has no positive counterpart.
// It passes through unchanged and is flagged.
module abs16 (
  input  logic [15:0] a,
  output logic [15:0] y,
  output logic        ovf
);
  assign y   = a[15] ? (~a + 16'd1) : a;
  assign ovf = (a == 16'h8000);
endmodule

module abs16_rr_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_ovf,
  input  logic              rsp_ready,
  output logic [7:0]        ovf_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_nxt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            found;
  logic [IDW:0]    idx;
  logic            cap;
  logic            accept;
  logic [N-1:0]    op;
  logic [15:0]     abs_y;
  logic            abs_ovf;

  // Rotating search starting at ptr_q. The extra bit in idx absorbs
  // ptr+k before the wrap, so non-power-of-two NREQ also wraps correctly.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found                = 1'b1;
        grant[idx[IDW-1:0]]  = 1'b1;
        gidx                 = idx[IDW-1:0];
      end
    end
  end

  // A slot is free when the register is empty or drains this edge.
  // rst_n gates the grant, so nothing is accepted while reset is held.
  assign cap       = ~rsp_valid | rsp_ready;
  assign req_ready = (rst_n && cap) ? grant : '0;
  assign accept    = |req_ready;

  // Operand mux feeds the single shared datapath. gidx depends only on
  // valids and ptr, so req_data never reaches req_ready.
  assign op = req_data[int'(gidx)*N +: N];

  abs16 u_abs (
    .a   (op),
    .y   (abs_y),
    .ovf (abs_ovf)
  );

  assign ptr_nxt = (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;

  // Response-register occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign rsp_valid = (state_q == FULL);

  // Payload loads only on accept. On a plain consume it holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_ovf  <= 1'b0;
      ptr_q    <= '0;
    end else if (accept) begin
      rsp_data <= abs_y;
      rsp_id   <= gidx;
      rsp_ovf  <= abs_ovf;
      ptr_q    <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        ovf_count <= '0;
    else if (accept && abs_ovf && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end

endmodule

// File: tb/tb_abs16_rr_arbiter.sv
module tb_abs16_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ovf;
  logic        rsp_ready;
  logic [7:0]  ovf_count;

  int n_vec = 0;
  int n_err = 0;

  abs16_rr_arbiter #(.N(16), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf),
    .rsp_ready (rsp_ready),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [63:0] data;
    logic        rr;
    logic [3:0]  rdy;
    logic        rv;
    logic [15:0] dat;
    logic [1:0]  id;
    logic        ovf;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, check req_ready before the rising edge,
  // then check the registered response just after it.
  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    req_valid = v.vld;
    req_data  = v.data;
    rsp_ready = v.rr;
    #1;
    chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(v.rv));
    chk($sformatf("v%0d rsp_data", i),  32'(rsp_data),  32'(v.dat));
    chk($sformatf("v%0d rsp_id", i),    32'(rsp_id),    32'(v.id));
    chk($sformatf("v%0d rsp_ovf", i),   32'(rsp_ovf),   32'(v.ovf));
    chk($sformatf("v%0d ovf_count", i), 32'(ovf_count), 32'(v.cnt));
  endtask

  initial begin
    logic [63:0] df, bp;
    df = {16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001};
    bp = {16'h0000, 16'hFF00, 16'h0000, 16'h0000};
    // single requester
    tbl[0]  = '{4'b0001, {48'h0, 16'hFFFB}, 1'b1, 4'b0001, 1'b1, 16'h0005, 2'd0, 1'b0, 8'd0};
    tbl[1]  = '{4'b0001, {48'h0, 16'h7FFF}, 1'b1, 4'b0001, 1'b1, 16'h7FFF, 2'd0, 1'b0, 8'd0};
    tbl[2]  = '{4'b0000, 64'h0,             1'b1, 4'b0000, 1'b0, 16'h7FFF, 2'd0, 1'b0, 8'd0};
    // fairness, ptr=1 here: 1,2,3,0 back to back
    tbl[3]  = '{4'b1111, df,                1'b1, 4'b0010, 1'b1, 16'h0002, 2'd1, 1'b0, 8'd0};
    tbl[4]  = '{4'b1111, df,                1'b1, 4'b0100, 1'b1, 16'h0003, 2'd2, 1'b0, 8'd0};
    tbl[5]  = '{4'b1111, df,                1'b1, 4'b1000, 1'b1, 16'h0004, 2'd3, 1'b0, 8'd0};
    tbl[6]  = '{4'b1111, df,                1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0, 1'b0, 8'd0};
    tbl[7]  = '{4'b0000, 64'h0,             1'b1, 4'b0000, 1'b0, 16'h0001, 2'd0, 1'b0, 8'd0};
    // overflow operand, ptr -> 2
    tbl[8]  = '{4'b0010, {32'h0, 16'h8000, 16'h0}, 1'b1, 4'b0010, 1'b1, 16'h8000, 2'd1, 1'b1, 8'd1};
    // pointer skip from ptr=2: 3 then 1, ptr ends at 2
    tbl[9]  = '{4'b1010, {16'hFFF0, 16'h0, 16'h0020, 16'h0}, 1'b1, 4'b1000, 1'b1, 16'h0010, 2'd3, 1'b0, 8'd1};
    tbl[10] = '{4'b0010, {16'hFFF0, 16'h0, 16'h0020, 16'h0}, 1'b1, 4'b0010, 1'b1, 16'h0020, 2'd1, 1'b0, 8'd1};
    tbl[11] = '{4'b0000, 64'h0,             1'b1, 4'b0000, 1'b0, 16'h0020, 2'd1, 1'b0, 8'd1};
    tbl[12] = '{4'b1111, df,                1'b1, 4'b0100, 1'b1, 16'h0003, 2'd2, 1'b0, 8'd1};
    // backpressure, req2 pending
    tbl[13] = '{4'b0100, bp,                1'b0, 4'b0000, 1'b1, 16'h0003, 2'd2, 1'b0, 8'd1};
    tbl[14] = '{4'b0100, bp,                1'b0, 4'b0000, 1'b1, 16'h0003, 2'd2, 1'b0, 8'd1};
    tbl[15] = '{4'b0100, bp,                1'b0, 4'b0000, 1'b1, 16'h0003, 2'd2, 1'b0, 8'd1};
    tbl[16] = '{4'b0100, bp,                1'b1, 4'b0100, 1'b1, 16'h0100, 2'd2, 1'b0, 8'd1};
    tbl[17] = '{4'b0000, 64'h0,             1'b0, 4'b0000, 1'b1, 16'h0100, 2'd2, 1'b0, 8'd1};
    tbl[18] = '{4'b0000, 64'h0,             1'b1, 4'b0000, 1'b0, 16'h0100, 2'd2, 1'b0, 8'd1};

    // reset state
    rst_n = 1'b0; req_valid = 4'b1111; req_data = df; rsp_ready = 1'b1;
    #12;
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst rsp_data",  32'(rsp_data),  32'h0);
    chk("rst rsp_id",    32'(rsp_id),    32'h0);
    chk("rst rsp_ovf",   32'(rsp_ovf),   32'h0);
    chk("rst ovf_count", 32'(ovf_count), 32'h0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) apply(i, tbl[i]);

    // saturation: 300 more 0x8000 operands on req1, count starts at 1
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      req_valid = 4'b0010; req_data = {32'h0, 16'h8000, 16'h0}; rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      if (k == 253) chk("sat cnt@254", 32'(ovf_count), 32'd254);
      if (k == 254) chk("sat cnt@255", 32'(ovf_count), 32'd255);
    end
    chk("sat cnt end",  32'(ovf_count), 32'd255);
    chk("sat rsp_data", 32'(rsp_data),  32'h8000);
    chk("sat rsp_ovf",  32'(rsp_ovf),   32'h1);

    // stall while full, then reset mid-cycle
    @(negedge clk);
    req_valid = 4'b0000; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("stall rsp_valid", 32'(rsp_valid), 32'h1);
    #2;
    rst_n = 1'b0; req_valid = 4'b1111;
    #1;
    chk("mid rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid rst rsp_data",  32'(rsp_data),  32'h0);
    chk("mid rst ovf_count", 32'(ovf_count), 32'h0);
    chk("mid rst req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("mid rst held rdy", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010; req_data = {16'h0001, 16'h0, 16'hFFF7, 16'h0}; rsp_ready = 1'b1;
    #1;
    chk("post rst req_ready", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk("post rst rsp_id",   32'(rsp_id),   32'd1);
    chk("post rst rsp_data", 32'(rsp_data), 32'h0009);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/abs16_rr_arbiter.md
# abs16_rr_arbiter

Round-robin arbiter that shares one combinational `abs16` absolute-value datapath between `NREQ` requesters. It has a valid/ready request port per requester and a single registered response port tagged with the requester index. It sits between multiple producers of signed 16-bit samples and any consumer needing magnitudes. It replaces per-requester `abs16` instances with one shared instance plus one output register.

## Interface
- `N`, 16: data width. Fixed at 16 to match `abs16`; other values are unsupported.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, $clog2(NREQ): width of the response tag.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_data`  in  NREQ*N  two's-complement operands; requester i uses bits [i*N +: N].
- `req_ready`  out  NREQ  one-hot-or-zero accept; combinational.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_data`  out  N  |operand| as returned by `abs16`.
- `rsp_id`  out  IDW  index of the requester that produced `rsp_data`.
- `rsp_ovf`  out  1  operand was 0x8000; `rsp_data` is 0x8000 (no saturation).
- `rsp_ready`  in  1  consumer accepts the response.
- `ovf_count`  out  8  saturating count of accepted 0x8000 operands.

## Operation
- Capacity: `cap = !rsp_valid | rsp_ready`.
- Grant: when `cap`=1, grant the first i with `req_valid[i]`=1, searching from `ptr` upward modulo NREQ. `req_ready[i]` = grant[i]. When `cap`=0, `req_ready` is all zero.
- Accept = any `req_ready` bit high. On an accept edge:
  - `rsp_data` <= `abs16(req_data[g])`, where the operand is muxed by grant g into the single `abs16` instance.
  - `rsp_id` <= g.
  - `rsp_ovf` <= (operand == 0x8000).
  - `rsp_valid` <= 1.
  - `ptr` <= (g+1) mod NREQ.
- Consume without accept (`rsp_valid & rsp_ready`, no request): `rsp_valid` <= 0. Data, id and ovf hold their last values.
- Simultaneous consume and accept: the new result loads on the same edge and `rsp_valid` stays 1. This gives a throughput of 1 result per cycle.
- Stall (`rsp_valid`=1, `rsp_ready`=0): the response registers hold, no grant is issued, and `ptr` holds.
- No request: `ptr` is unchanged.
- Requester rule: once `req_valid` is raised, it and `req_data` stay stable until `req_ready`. The block does not check this rule.
- Consumer rule: `rsp_valid`, `rsp_data`, `rsp_id` and `rsp_ovf` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- `ovf_count` increments on each accept with an operand of 0x8000 and saturates at 255.
- States:
  - EMPTY (`rsp_valid`=0) goes to FULL on accept.
  - FULL goes to EMPTY on consume without accept.
  - FULL stays FULL on stall, or on consume with accept.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_ovf`=0, `ovf_count`=0, `ptr`=0. Reset is applied asynchronously and released synchronously to `clk`.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`. There is no combinational path from `req_data`.
- Latency: a request accepted at edge k yields `rsp_valid`=1 with its result after edge k, i.e. in cycle k+1.
- Critical path: grant → operand mux → `abs16` carry chain → `rsp_data` D input. This path must meet one cycle.
- Reset mid-operation: any held response is discarded, `ptr` returns to 0, and no `req_ready` is asserted while `rst_n`=0.

## Test plan
- Single requester: req0 sends 0xFFFB (−5) with `rsp_ready`=1. The next cycle shows `rsp_valid`=1, `rsp_data`=0x0005, `rsp_id`=0, `rsp_ovf`=0. Then send 0x7FFF and expect 0x7FFF.
- Fairness: all 4 `req_valid` are held high with `rsp_ready`=1. Grants go 0,1,2,3,0,1… on consecutive cycles, with one `rsp_valid` per cycle and no bubble.
- Backpressure: `rsp_ready`=0 for 3 cycles while FULL with req2 pending. `req_ready` stays 0 and `rsp_data`/`rsp_id` stay stable. On the `rsp_ready` rise, req2 is granted in the same cycle.
- Overflow: req1 sends 0x8000. Expect `rsp_data`=0x8000, `rsp_ovf`=1 and `ovf_count`=1. After 300 such operands, `ovf_count`=255.
- Pointer skip: only req3 and req1 are valid with `ptr`=2. Grant order is 3, then 1, and `ptr` ends at 2.
- Reset mid-stall: assert `rst_n`=0 while FULL. `rsp_valid`, `rsp_data` and `ovf_count` go to 0 immediately. After release, the first grant goes to the lowest valid index at or above 0.
